// File: rtl/scr1_dmem_router_if.sv
// Data memory channel: request fields from the initiator and the handshake,
// response and read data returned by the target.
interface scr1_dmem_router_if;
    logic        req;
    logic        cmd;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_ack;
    logic [31:0] rdata;
    logic [1:0]  resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );
endinterface

// File: rtl/scr1_dmem_router.sv
// Data memory router: decodes each core request address onto one of three
// target ports (TCM, timer, external bus). It tracks the single outstanding
// transaction and muxes that port's response straight back to the core.
// A new request may be accepted in the same cycle the previous one completes.
module scr1_dmem_router #(
    parameter logic [31:0] PORT0_ADDR_MASK    = 32'hFFFF0000,
    parameter logic [31:0] PORT0_ADDR_PATTERN = 32'h00480000,
    parameter logic [31:0] PORT1_ADDR_MASK    = 32'hFFFFFFE0,
    parameter logic [31:0] PORT1_ADDR_PATTERN = 32'h00490000
) (
    input  logic               clk,
    input  logic               rst,
    scr1_dmem_router_if.slave  dmem,
    scr1_dmem_router_if.master port0,
    scr1_dmem_router_if.master port1,
    scr1_dmem_router_if.master port2
);

    localparam logic [1:0] RESP_IDLE   = 2'd0;
    localparam logic [1:0] RESP_RDY_OK = 2'd1;
    localparam logic [1:0] RESP_RDY_ER = 2'd2;

    typedef enum logic {
        ST_ADDR,
        ST_DATA
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  port_q, port_d;

    logic [1:0]  sel;
    logic        sel_ack;
    logic [1:0]  act_resp;
    logic [31:0] act_rdata;
    logic        resp_done;
    logic        can_issue;
    logic        accept;

    // Request fields are broadcast to every port unregistered
    assign port0.cmd   = dmem.cmd;
    assign port0.width = dmem.width;
    assign port0.addr  = dmem.addr;
    assign port0.wdata = dmem.wdata;
    assign port1.cmd   = dmem.cmd;
    assign port1.width = dmem.width;
    assign port1.addr  = dmem.addr;
    assign port1.wdata = dmem.wdata;
    assign port2.cmd   = dmem.cmd;
    assign port2.width = dmem.width;
    assign port2.addr  = dmem.addr;
    assign port2.wdata = dmem.wdata;

    // Address decode; port 0 wins when both windows match, port 2 is the default
    always_comb begin
        sel = 2'd2;
        if ((dmem.addr & PORT0_ADDR_MASK) == PORT0_ADDR_PATTERN) begin
            sel = 2'd0;
        end else if ((dmem.addr & PORT1_ADDR_MASK) == PORT1_ADDR_PATTERN) begin
            sel = 2'd1;
        end
    end

    // Acknowledge from the port the current request decodes to
    always_comb begin
        case (sel)
            2'd0:    sel_ack = port0.req_ack;
            2'd1:    sel_ack = port1.req_ack;
            default: sel_ack = port2.req_ack;
        endcase
    end

    // Response and read data from the port owning the outstanding transaction
    always_comb begin
        case (port_q)
            2'd0: begin
                act_resp  = port0.resp;
                act_rdata = port0.rdata;
            end
            2'd1: begin
                act_resp  = port1.resp;
                act_rdata = port1.rdata;
            end
            default: begin
                act_resp  = port2.resp;
                act_rdata = port2.rdata;
            end
        endcase
    end

    // Issue qualification, request forwarding and core acknowledge
    always_comb begin
        resp_done    = (state_q == ST_DATA) &&
                       ((act_resp == RESP_RDY_OK) || (act_resp == RESP_RDY_ER));
        can_issue    = !rst && ((state_q == ST_ADDR) || resp_done);
        accept       = dmem.req && can_issue && sel_ack;
        port0.req    = dmem.req && can_issue && (sel == 2'd0);
        port1.req    = dmem.req && can_issue && (sel == 2'd1);
        port2.req    = dmem.req && can_issue && (sel == 2'd2);
        dmem.req_ack = accept;
    end

    // Core response: only the owning port's response, and only while awaiting it
    always_comb begin
        dmem.resp  = RESP_IDLE;
        dmem.rdata = '0;
        if (!rst && (state_q == ST_DATA)) begin
            dmem.resp = act_resp;
            if (act_resp == RESP_RDY_OK) begin
                dmem.rdata = act_rdata;
            end
        end
    end

    // Next state: an accept always lands in DATA with the new owner; completion
    // without a fresh accept returns to ADDR
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        case (state_q)
            ST_ADDR: begin
                if (accept) begin
                    state_d = ST_DATA;
                    port_d  = sel;
                end
            end
            ST_DATA: begin
                if (resp_done) begin
                    if (accept) begin
                        port_d = sel;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            default: state_d = ST_ADDR;
        endcase
    end

    // Transaction tracking registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ADDR;
            port_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
        end
    end

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Testbench for scr1_dmem_router: scripted port behaviour per scenario, a
// scoreboard of expected core responses, and a monitor that pops and
// compares every non-idle response seen by the core.
module tb_scr1_dmem_router;

    localparam logic [1:0] RESP_IDLE   = 2'd0;
    localparam logic [1:0] RESP_RDY_OK = 2'd1;
    localparam logic [1:0] RESP_RDY_ER = 2'd2;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    exp_t exp_q[$];
    exp_t mon_e;

    scr1_dmem_router_if dmem_if ();
    scr1_dmem_router_if p0_if ();
    scr1_dmem_router_if p1_if ();
    scr1_dmem_router_if p2_if ();

    logic [2:0] reqs;
    assign reqs = {p0_if.req, p1_if.req, p2_if.req};

    scr1_dmem_router #(
        .PORT0_ADDR_MASK    (32'hFFFF0000),
        .PORT0_ADDR_PATTERN (32'h00480000),
        .PORT1_ADDR_MASK    (32'hFFFFFFE0),
        .PORT1_ADDR_PATTERN (32'h00490000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .dmem  (dmem_if),
        .port0 (p0_if),
        .port1 (p1_if),
        .port2 (p2_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary before 200000");
        $fatal(1, "simulation timeout");
    end

    // Monitor: at most one port request, and every core response matches the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (int'(p0_if.req) + int'(p1_if.req) + int'(p2_if.req) > 1) begin
                n_fail++;
                $display("FAIL onehot_req: got %b expected at most one bit set", reqs);
            end
            if (dmem_if.resp !== RESP_IDLE) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got resp %h rdata %h expected no response",
                             dmem_if.resp, dmem_if.rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({dmem_if.resp, dmem_if.rdata} !== {mon_e.resp, mon_e.rdata}) begin
                        n_fail++;
                        $display("FAIL sb_resp: got %h/%h expected %h/%h",
                                 dmem_if.resp, dmem_if.rdata, mon_e.resp, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dmem_if.req   = 1'b0;
        dmem_if.cmd   = 1'b0;
        dmem_if.width = 2'd0;
        dmem_if.addr  = 32'h0;
        dmem_if.wdata = 32'h0;
        p0_if.req_ack = 1'b0; p0_if.resp = RESP_IDLE; p0_if.rdata = 32'h0;
        p1_if.req_ack = 1'b0; p1_if.resp = RESP_IDLE; p1_if.rdata = 32'h0;
        p2_if.req_ack = 1'b0; p2_if.resp = RESP_IDLE; p2_if.rdata = 32'h0;
    endtask

    task automatic drive_req(input logic cmd, input logic [1:0] width,
                             input logic [31:0] addr, input logic [31:0] wdata);
        dmem_if.req   = 1'b1;
        dmem_if.cmd   = cmd;
        dmem_if.width = width;
        dmem_if.addr  = addr;
        dmem_if.wdata = wdata;
    endtask

    task automatic push_exp(input logic [1:0] resp, input logic [31:0] rdata);
        exp_t e;
        e.resp  = resp;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        drive_req(1'b1, 2'd1, 32'h00480000, 32'h55AA55AA);
        p0_if.req_ack = 1'b1; p0_if.resp = RESP_RDY_OK; p0_if.rdata = 32'h12345678;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_req: got %b expected 0000", {reqs, dmem_if.req_ack});
        end
        n_cmp++;
        if ({dmem_if.resp, dmem_if.rdata} !== {RESP_IDLE, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_resp: got %h/%h expected 0/00000000", dmem_if.resp, dmem_if.rdata);
        end
        n_cmp++;
        if ({p2_if.cmd, p2_if.width, p2_if.addr, p2_if.wdata} !== {1'b1, 2'd1, 32'h00480000, 32'h55AA55AA}) begin
            n_fail++;
            $display("FAIL reset_bcast: got %h expected %h",
                     {p2_if.cmd, p2_if.width, p2_if.addr, p2_if.wdata},
                     {1'b1, 2'd1, 32'h00480000, 32'h55AA55AA});
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_read_port0();
        drive_req(1'b0, 2'd2, 32'h00480010, 32'h0);
        p0_if.req_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack} !== 4'b1001) begin
            n_fail++;
            $display("FAIL rd0_accept: got %b expected 1001", {reqs, dmem_if.req_ack});
        end
        push_exp(RESP_RDY_OK, 32'hDEADBEEF);
        next_cycle();
        dmem_if.req = 1'b0; p0_if.req_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack, dmem_if.resp} !== {4'b0000, RESP_IDLE}) begin
            n_fail++;
            $display("FAIL rd0_wait: got %b expected 000000", {reqs, dmem_if.req_ack, dmem_if.resp});
        end
        next_cycle();
        p0_if.resp = RESP_RDY_OK; p0_if.rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if ({dmem_if.resp, dmem_if.rdata} !== {RESP_RDY_OK, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL rd0_resp: got %h/%h expected 1/deadbeef", dmem_if.resp, dmem_if.rdata);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, 2'd2, 32'h00490004, 32'h12345678);
        p1_if.req_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack, p1_if.cmd, p1_if.wdata} !== {4'b0101, 1'b1, 32'h12345678}) begin
            n_fail++;
            $display("FAIL b2b_wr_accept: got %h expected %h",
                     {reqs, dmem_if.req_ack, p1_if.cmd, p1_if.wdata}, {4'b0101, 1'b1, 32'h12345678});
        end
        push_exp(RESP_RDY_OK, 32'hA5A5A5A5);
        // Core presents the next request while the write is still outstanding
        next_cycle();
        p1_if.req_ack = 1'b0;
        drive_req(1'b0, 2'd2, 32'h20000000, 32'h0);
        p2_if.req_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack, dmem_if.resp} !== {4'b0000, RESP_IDLE}) begin
            n_fail++;
            $display("FAIL b2b_hold: got %b expected 000000", {reqs, dmem_if.req_ack, dmem_if.resp});
        end
        next_cycle();
        p1_if.resp = RESP_RDY_OK; p1_if.rdata = 32'hA5A5A5A5;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack} !== 4'b0011) begin
            n_fail++;
            $display("FAIL b2b_rd_accept: got %b expected 0011", {reqs, dmem_if.req_ack});
        end
        push_exp(RESP_RDY_OK, 32'hCAFEF00D);
        next_cycle();
        dmem_if.req = 1'b0; p2_if.req_ack = 1'b0;
        p1_if.resp = RESP_IDLE;
        p2_if.resp = RESP_RDY_OK; p2_if.rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_cmp++;
        if ({dmem_if.resp, dmem_if.rdata} !== {RESP_RDY_OK, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL b2b_rd_resp: got %h/%h expected 1/cafef00d", dmem_if.resp, dmem_if.rdata);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (dmem_if.resp !== RESP_IDLE) begin
            n_fail++;
            $display("FAIL b2b_done: got %h expected 0", dmem_if.resp);
        end
        next_cycle();
    endtask

    task automatic test_ack_stall();
        drive_req(1'b0, 2'd2, 32'h20000000, 32'h0);
        p0_if.req_ack = 1'b1; p1_if.req_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            n_cmp++;
            if ({reqs, dmem_if.req_ack} !== 4'b0010) begin
                n_fail++;
                $display("FAIL stall_%0d: got %b expected 0010", i, {reqs, dmem_if.req_ack});
            end
        end
        next_cycle();
        p2_if.req_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack} !== 4'b0011) begin
            n_fail++;
            $display("FAIL stall_accept: got %b expected 0011", {reqs, dmem_if.req_ack});
        end
        push_exp(RESP_RDY_OK, 32'h0BADCAFE);
        next_cycle();
        idle_inputs();
        p2_if.resp = RESP_RDY_OK; p2_if.rdata = 32'h0BADCAFE;
        @(negedge clk);
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_error();
        drive_req(1'b0, 2'd2, 32'h20000100, 32'h0);
        p2_if.req_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack} !== 4'b0011) begin
            n_fail++;
            $display("FAIL err_accept: got %b expected 0011", {reqs, dmem_if.req_ack});
        end
        push_exp(RESP_RDY_ER, 32'h0);
        next_cycle();
        dmem_if.req = 1'b0; p2_if.req_ack = 1'b0;
        p2_if.resp = RESP_RDY_ER; p2_if.rdata = 32'hFFFFFFFF;
        p0_if.resp = RESP_RDY_OK; p0_if.rdata = 32'h11111111;
        @(negedge clk);
        n_cmp++;
        if ({dmem_if.resp, dmem_if.rdata} !== {RESP_RDY_ER, 32'h0}) begin
            n_fail++;
            $display("FAIL err_resp: got %h/%h expected 2/00000000", dmem_if.resp, dmem_if.rdata);
        end
        // Back in ADDR: the lingering port0 response must be ignored, new request forwarded
        next_cycle();
        p2_if.resp = RESP_IDLE; p2_if.rdata = 32'h0;
        drive_req(1'b0, 2'd2, 32'h00480020, 32'h0);
        p0_if.req_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack, dmem_if.resp} !== {4'b1001, RESP_IDLE}) begin
            n_fail++;
            $display("FAIL err_then_addr: got %b expected 100100", {reqs, dmem_if.req_ack, dmem_if.resp});
        end
        push_exp(RESP_RDY_OK, 32'h22222222);
        next_cycle();
        dmem_if.req = 1'b0; p0_if.req_ack = 1'b0;
        p0_if.resp = RESP_RDY_OK; p0_if.rdata = 32'h22222222;
        @(negedge clk);
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        drive_req(1'b0, 2'd2, 32'h00480000, 32'h0);
        p0_if.req_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack} !== 4'b1001) begin
            n_fail++;
            $display("FAIL rstmid_accept: got %b expected 1001", {reqs, dmem_if.req_ack});
        end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack, dmem_if.resp, dmem_if.rdata} !== {4'b0000, RESP_IDLE, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_hold: got %h expected 0",
                     {reqs, dmem_if.req_ack, dmem_if.resp, dmem_if.rdata});
        end
        next_cycle();
        rst = 1'b0;
        p0_if.resp = RESP_RDY_OK; p0_if.rdata = 32'h33333333;
        @(negedge clk);
        n_cmp++;
        if ({dmem_if.resp, dmem_if.rdata} !== {RESP_IDLE, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_late: got %h/%h expected 0/00000000", dmem_if.resp, dmem_if.rdata);
        end
        next_cycle();
        p0_if.resp = RESP_IDLE; p0_if.rdata = 32'h0;
        drive_req(1'b0, 2'd2, 32'h00480000, 32'h0);
        p0_if.req_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({reqs, dmem_if.req_ack} !== 4'b1001) begin
            n_fail++;
            $display("FAIL rstmid_reissue: got %b expected 1001", {reqs, dmem_if.req_ack});
        end
        push_exp(RESP_RDY_OK, 32'h44444444);
        next_cycle();
        dmem_if.req = 1'b0; p0_if.req_ack = 1'b0;
        p0_if.resp = RESP_RDY_OK; p0_if.rdata = 32'h44444444;
        @(negedge clk);
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_decode();
        logic [31:0] addrs [5];
        logic [2:0]  sels  [5];
        logic [31:0] exp_data;
        addrs[0] = 32'h00490040; sels[0] = 3'b001;
        addrs[1] = 32'h0049001F; sels[1] = 3'b010;
        addrs[2] = 32'h0048FFFC; sels[2] = 3'b100;
        addrs[3] = 32'h00470000; sels[3] = 3'b001;
        addrs[4] = 32'h00490020; sels[4] = 3'b001;
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b0, 2'd2, addrs[i], 32'h0);
            p0_if.req_ack = 1'b1; p1_if.req_ack = 1'b1; p2_if.req_ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({reqs, dmem_if.req_ack} !== {sels[i], 1'b1}) begin
                n_fail++;
                $display("FAIL decode_%h: got %b expected %b", addrs[i],
                         {reqs, dmem_if.req_ack}, {sels[i], 1'b1});
            end
            case (sels[i])
                3'b100:  exp_data = 32'hB0000000 | 32'(i);
                3'b010:  exp_data = 32'hC0000000 | 32'(i);
                default: exp_data = 32'hD0000000 | 32'(i);
            endcase
            push_exp(RESP_RDY_OK, exp_data);
            next_cycle();
            idle_inputs();
            p0_if.resp = RESP_RDY_OK; p0_if.rdata = 32'hB0000000 | 32'(i);
            p1_if.resp = RESP_RDY_OK; p1_if.rdata = 32'hC0000000 | 32'(i);
            p2_if.resp = RESP_RDY_OK; p2_if.rdata = 32'hD0000000 | 32'(i);
            @(negedge clk);
            next_cycle();
            idle_inputs();
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_read_port0();
        test_back_to_back();
        test_ack_stall();
        test_error();
        test_reset_mid();
        test_decode();
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/scr1_dmem_router.md
Name: scr1_dmem_router

Overview:
- Sits directly downstream of the load/store unit on the data memory interface.
- Steers each core DMEM request to one of three target ports by address: TCM, memory-mapped timer, or external bus.
- Tracks the single outstanding transaction and returns that port's response and read data to the core.
- Supports back-to-back transactions: a new request may be issued in the same cycle the previous response returns.

Parameters:
- PORT0_ADDR_MASK, 32'hFFFF0000, address mask for port 0 (TCM)
- PORT0_ADDR_PATTERN, 32'h00480000, match pattern for port 0
- PORT1_ADDR_MASK, 32'hFFFFFFE0, address mask for port 1 (timer)
- PORT1_ADDR_PATTERN, 32'h00490000, match pattern for port 1
- Port 2 (external) is the default for all non-matching addresses.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- dmem_req  input  1  core request valid
- dmem_cmd  input  1  0=RD, 1=WR
- dmem_width  input  2  0=BYTE, 1=HWORD, 2=WORD
- dmem_addr  input  32  request address
- dmem_wdata  input  32  store data
- dmem_req_ack  output  1  request accepted
- dmem_rdata  output  32  load data
- dmem_resp  output  2  0=IDLE, 1=RDY_OK, 2=RDY_ER
- portN_req  output  1  request to port N (N=0,1,2)
- portN_cmd / portN_width / portN_addr / portN_wdata  output  1/2/32/32  broadcast copies of core fields
- portN_req_ack  input  1  port N accepted the request
- portN_rdata  input  32  port N read data
- portN_resp  input  2  port N response

Behaviour:
- Port select (combinational): sel=0 if (dmem_addr & PORT0_ADDR_MASK)==PORT0_ADDR_PATTERN; else sel=1 if the PORT1 pair matches; else sel=2. Port 0 has priority when both match.
- State: 1-bit FSM {ADDR, DATA} and a 2-bit register port_r.
- Reset values: FSM=ADDR, port_r=0.
- While rst is asserted: all portN_req=0, dmem_req_ack=0, dmem_resp=IDLE, dmem_rdata=0.
- cmd, width, addr and wdata pass unregistered to all three ports at all times.
- Definition: can_issue = (FSM==ADDR) | (FSM==DATA & resp_done), where resp_done = portN_resp of port_r is RDY_OK or RDY_ER.
- Request forwarding: portN_req = dmem_req & can_issue & (sel==N). At most one portN_req is high in any cycle.
- dmem_req_ack = dmem_req & can_issue & portN_req_ack of the selected port. Zero latency: acceptance happens in the same cycle.
- ADDR state:
  - dmem_resp=IDLE, dmem_rdata=0.
  - On accept (dmem_req_ack=1): FSM->DATA, port_r<=sel.
  - A request that is not acked keeps FSM in ADDR; the core holds its request.
- DATA state:
  - dmem_resp = portN_resp of port_r; dmem_rdata = portN_rdata of port_r, forced to 0 unless resp is RDY_OK.
  - If resp is IDLE: no port request is forwarded, dmem_req_ack=0, state holds.
  - If resp_done and a new request is accepted in the same cycle: stay DATA, port_r<=new sel.
  - If resp_done and no accept: FSM->ADDR.
- Response latency: the core sees a port response in the same cycle it arrives (combinational mux, no added cycles).
- Responses on non-selected ports (any resp other than IDLE on a port other than port_r, or any resp in ADDR) are ignored and never reach the core.
- RDY_ER from a port is passed through unchanged. The router itself never generates errors.
- Reset mid-operation: the outstanding transaction is abandoned; after rst deasserts, FSM=ADDR and late responses are ignored.
- Throughput: one transaction per cycle when ports ack and respond in the next cycle.

Test Plan:
- Read to 0x00480010, port0 acks in cycle 0 and returns RDY_OK with rdata 0xDEADBEEF in cycle 2 -> only port0_req pulses; dmem_req_ack=1 in cycle 0; dmem_resp=RDY_OK with 0xDEADBEEF in cycle 2 and IDLE in cycle 1.
- Write to 0x00490004 (timer), then read to 0x20000000 (external) issued in the response cycle of the write -> port1 then port2 requested; second ack in the same cycle as the first RDY_OK; FSM stays DATA; port_r=2.
- Request to 0x20000000 with port2_req_ack low for 3 cycles -> dmem_req_ack=0 for 3 cycles, port2_req held high, accept on cycle 4; no other port requested.
- port2 returns RDY_ER on read -> dmem_resp=RDY_ER, dmem_rdata=0, FSM->ADDR; a spurious port0_resp=RDY_OK in the same cycle is ignored.
- rst asserted while in DATA awaiting port0, then port0 responds RDY_OK after release -> dmem_resp stays IDLE; the next request to 0x00480000 is accepted normally.
- Address 0x00490040 (outside the port1 mask) -> routed to port2, not port1.
